seg7_scan_decoder: RTL and testbench
====================================

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, is the number of consecutive identical (an, seg) samples required before a digit is captured; legal range 2..255.
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: an  input  4  digit anodes, active-low; an[i]=0 selects digit i (digit 3 is the most significant).
REQ-005 Port: seg  input  7  segment lines, active-low, seg[0]=a … seg[6]=g.
REQ-006 Port: value  output  16  last complete frame, digit i in value[4i+3:4i].
REQ-007 Port: valid  output  1  one-cycle pulse when value updates.
REQ-008 Port: err  output  1  one-cycle pulse on capture of an undecodable non-blank pattern.
REQ-009 Port: blank  output  4  blank[i]=1 when digit i of the last frame had all segments off.

Function
REQ-010 Decode table, as seg[6:0], SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-011 The selection is legal only when exactly one bit of an is 0; any other an value is treated as idle.
REQ-012 The FSM SHALL have three states: WAIT, COUNT and HOLD.
REQ-013 WAIT: on a legal selection, load the sample register with (an, seg), set cnt=1 and go to COUNT.
REQ-014 COUNT: a sample equal to the register increments cnt; a differing legal sample reloads with cnt=1; an illegal sample returns to WAIT.
REQ-015 COUNT: when cnt reaches STABLE_CYCLES, the current digit is captured and the FSM goes to HOLD; capture latency is STABLE_CYCLES cycles after the first matching sample.
REQ-016 HOLD: no recapture occurs while the sample is unchanged; any change returns to WAIT, and that changed sample is evaluated in the same cycle as a WAIT sample.
REQ-017 If the sample changes in the same cycle cnt would reach STABLE_CYCLES, the change wins and no capture occurs.
REQ-018 On capture of digit i, the nibble is stored to the pending slot i and got[i] is set.
REQ-019 A capture with all segments off stores nibble 0 and sets pending blank bit i.
REQ-020 A capture with any other unlisted pattern stores 0, pulses err on the next cycle and still sets got[i].
REQ-021 A recapture of an already-got digit overwrites its pending slot.
REQ-022 When got becomes 4'b1111, on the next cycle value and blank load from the pending slots, valid pulses for one cycle, and got clears; valid and a new capture in the same cycle are both honoured.
REQ-023 The cnt width is 8 bits and saturates; it never wraps.

Reset
REQ-024 While rst_n=0 at a clock edge: FSM goes to WAIT, cnt=0, got=0, pending slots=0, value=16'h0000, valid=0, err=0, blank=4'b0000.
REQ-025 A reset asserted mid-frame discards all partial captures; the next valid SHALL require four fresh captures.

Structure
REQ-026 Shared package seg7_pkg SHALL hold the 16 pattern constants, the blank pattern 7'b1111111, FSM state encodings and the STABLE_CYCLES default.
REQ-027 One combinational sub-module, seg7_pattern_decode (seg → nibble, hit, is_blank), SHALL be instantiated once on the sample register.

Verification
REQ-028 Scan digits 3..0 showing 1, 2, A, F, each held 8 cycles -> valid pulses once, value=16'h12AF, blank=0000, err never asserts.
REQ-029 Hold each digit for only STABLE_CYCLES-1 cycles -> no capture and no valid.
REQ-030 Present an=4'b1100 with seg=0000000 for 20 cycles -> stays in WAIT, no capture.
REQ-031 Digit 2 seg=1111111, digit 1 seg=0110110, others 0 -> valid with value=16'h0000, blank=0100, err pulses exactly once.
REQ-032 Complete three digits, assert rst_n=0 for 1 cycle, then scan 4,3,2,1 -> a single valid with value=16'h4321.
REQ-033 Scan continuously with digit 0 changing from 5 to 7 between frames -> consecutive valids report ...5 then ...7, and no frame is lost at the valid/capture overlap.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan decoder: the active-low segment
// table, the blank pattern, FSM state encodings and anode helpers.
package seg7_pkg;

  localparam int STABLE_CYCLES_DEF = 4;

  // Segment patterns as seg[6:0] = g..a, active-low
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0011000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Exactly one anode driven low is a real digit selection.
  function automatic logic an_legal(input logic [3:0] an);
    return (an == 4'b1110) || (an == 4'b1101) || (an == 4'b1011) || (an == 4'b0111);
  endfunction

  function automatic logic [1:0] an_index(input logic [3:0] an);
    logic [1:0] idx;
    idx = 2'd0;
    if (!an[1]) idx = 2'd1;
    if (!an[2]) idx = 2'd2;
    if (!an[3]) idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to hex-nibble lookup; flags table hits and the
// all-segments-off pattern separately.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       hit,
  output logic       is_blank
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch.
    nibble = 4'h0;
    hit    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_TABLE[i]) begin
        nibble = 4'(i);
        hit    = 1'b1;
      end
    end
    is_blank = (seg == SEG_BLANK);
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers the four hex digits shown on a multiplexed, active-low 7-segment
// display by debouncing each (an, seg) sample and assembling complete frames.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] value,
  output logic        valid,
  output logic        err,
  output logic [3:0]  blank
);

  state_t          state;
  logic [3:0]      s_an;
  logic [6:0]      s_seg;
  logic [7:0]      cnt;
  logic [3:0]      got;
  logic [3:0][3:0] pend;
  logic [3:0]      pend_blank;

  logic [3:0] dec_nibble;
  logic       dec_hit;
  logic       dec_blank;

  seg7_pattern_decode u_decode (
    .seg      (s_seg),
    .nibble   (dec_nibble),
    .hit      (dec_hit),
    .is_blank (dec_blank)
  );

  logic       legal;
  logic       same;
  logic [7:0] cnt_inc;
  logic       capture;
  logic [1:0] cap_idx;
  logic [3:0] cap_mask;
  logic [3:0] got_base;

  assign legal    = an_legal(an);
  assign same     = (an == s_an) && (seg == s_seg);
  assign cnt_inc  = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  // A changed sample never captures: capture needs the match on this edge.
  assign capture  = (state == ST_COUNT) && same && (cnt_inc == 8'(STABLE_CYCLES));
  assign cap_idx  = an_index(s_an);
  assign cap_mask = capture ? (4'b0001 << cap_idx) : 4'b0000;
  assign got_base = (&got) ? 4'b0000 : got;

  // NOTE: all state is updated with non-blocking assignments so every branch
  // reads the pre-edge values, e.g. value loads the old pending slot even when
  // a capture overwrites it on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_WAIT;
      s_an       <= 4'hF;
      s_seg      <= SEG_BLANK;
      cnt        <= 8'd0;
      got        <= 4'b0000;
      // NOTE: the pending slots are a tiny register file, reset explicitly so
      // a frame started after reset can never expose stale digits.
      pend       <= '0;
      pend_blank <= 4'b0000;
      value      <= 16'h0000;
      valid      <= 1'b0;
      err        <= 1'b0;
      blank      <= 4'b0000;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;

      case (state)
        ST_WAIT: begin
          if (legal) begin
            s_an  <= an;
            s_seg <= seg;
            cnt   <= 8'd1;
            state <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (!legal) begin
            cnt   <= 8'd0;
            state <= ST_WAIT;
          end else if (!same) begin
            s_an  <= an;
            s_seg <= seg;
            cnt   <= 8'd1;
          end else begin
            cnt <= cnt_inc;
            if (capture) state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!same) begin
            if (legal) begin
              s_an  <= an;
              s_seg <= seg;
              cnt   <= 8'd1;
              state <= ST_COUNT;
            end else begin
              cnt   <= 8'd0;
              state <= ST_WAIT;
            end
          end
        end
        default: state <= ST_WAIT;
      endcase

      if (capture) begin
        pend[cap_idx]       <= dec_hit ? dec_nibble : 4'h0;
        pend_blank[cap_idx] <= dec_blank;
        err                 <= !dec_hit && !dec_blank;
      end

      if (&got) begin
        value <= pend;
        blank <= pend_blank;
        valid <= 1'b1;
      end
      got <= got_base | cap_mask;
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: a table of full frames plus
// hand-written sequences for debounce length, idle anodes and reset.
module tb_seg7_scan_decoder;

  localparam int STABLE = 4;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0011000, SA = 7'b0001000, SB = 7'b0000011;
  localparam logic [6:0] SC = 7'b1000110, SD = 7'b0100001, SE = 7'b0000110, SF = 7'b0001110;
  localparam logic [6:0] SBLANK = 7'b1111111;
  localparam logic [6:0] SBAD   = 7'b0110110;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] value;
  logic        valid;
  logic        err;
  logic [3:0]  blank;

  seg7_scan_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .an    (an),
    .seg   (seg),
    .value (value),
    .valid (valid),
    .err   (err),
    .blank (blank)
  );

  always #5 clk = ~clk;

  int          n_valid    = 0;
  int          n_err      = 0;
  logic [15:0] last_value = 16'h0;
  logic [15:0] prev_value = 16'h0;
  logic [3:0]  last_blank = 4'h0;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      n_valid    = n_valid + 1;
      prev_value = last_value;
      last_value = value;
      last_blank = blank;
    end
    if (err === 1'b1) n_err = n_err + 1;
  end

  typedef struct {
    logic [3:0][6:0] segs;
    logic [15:0]     exp_value;
    logic [3:0]      exp_blank;
    int              exp_err;
  } frame_t;

  frame_t tbl[6];
  int errors = 0;
  int checks = 0;
  int v0, e0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive_raw(input logic [3:0] a, input logic [6:0] s, input int n);
    repeat (n) begin
      @(negedge clk);
      an  = a;
      seg = s;
    end
  endtask

  task automatic drive(input int d, input logic [6:0] s, input int n);
    drive_raw(~(4'b0001 << d), s, n);
  endtask

  task automatic idle(input int n);
    drive_raw(4'hF, SBLANK, n);
  endtask

  task automatic scan(input logic [3:0][6:0] s, input int hold);
    for (int d = 3; d >= 0; d--) drive(d, s[d], hold);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    an    = 4'hF;
    seg   = SBLANK;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{segs: {S1, S2, SA, SF}, exp_value: 16'h12AF, exp_blank: 4'b0000, exp_err: 0};
    tbl[1] = '{segs: {S0, S1, S2, S3}, exp_value: 16'h0123, exp_blank: 4'b0000, exp_err: 0};
    tbl[2] = '{segs: {S4, S5, S6, S7}, exp_value: 16'h4567, exp_blank: 4'b0000, exp_err: 0};
    tbl[3] = '{segs: {S8, S9, SA, SB}, exp_value: 16'h89AB, exp_blank: 4'b0000, exp_err: 0};
    tbl[4] = '{segs: {SC, SD, SE, SF}, exp_value: 16'hCDEF, exp_blank: 4'b0000, exp_err: 0};
    tbl[5] = '{segs: {S0, SBLANK, SBAD, S0}, exp_value: 16'h0000, exp_blank: 4'b0100, exp_err: 1};

    rst_n = 1'b0;
    an    = 4'hF;
    seg   = SBLANK;
    repeat (3) @(negedge clk);
    #1;
    check("reset_value", 32'(value), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_err",   32'(err),   32'h0);
    check("reset_blank", 32'(blank), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      v0 = n_valid;
      e0 = n_err;
      scan(tbl[i].segs, 8);
      idle(3);
      settle();
      check($sformatf("frame%0d_valid_count", i), 32'(n_valid - v0), 32'd1);
      check($sformatf("frame%0d_value", i), 32'(last_value), 32'(tbl[i].exp_value));
      check($sformatf("frame%0d_blank", i), 32'(last_blank), 32'(tbl[i].exp_blank));
      check($sformatf("frame%0d_err_count", i), 32'(n_err - e0), 32'(tbl[i].exp_err));
    end

    // Each digit one sample short of the debounce length never captures.
    do_reset();
    v0 = n_valid;
    e0 = n_err;
    repeat (2) scan(tbl[0].segs, STABLE - 1);
    idle(4);
    settle();
    check("short_hold_valid_count", 32'(n_valid - v0), 32'd0);
    check("short_hold_err_count", 32'(n_err - e0), 32'd0);

    // Exact latency: digit 0 held STABLE samples completes the frame.
    v0 = n_valid;
    for (int d = 3; d >= 1; d--) drive(d, tbl[0].segs[d], 8);
    drive(0, SF, STABLE);
    @(negedge clk);
    check("latency_valid_early", 32'(valid), 32'h0);
    an  = 4'hF;
    seg = SBLANK;
    @(negedge clk);
    check("latency_valid_on_time", 32'(valid), 32'h1);
    check("latency_value", 32'(value), 32'h12AF);

    // Two anodes low is idle: no digit may be captured from it.
    do_reset();
    v0 = n_valid;
    drive_raw(4'b1100, 7'b0000000, 20);
    for (int d = 3; d >= 1; d--) drive(d, S6, 8);
    idle(4);
    settle();
    check("idle_anodes_no_valid", 32'(n_valid - v0), 32'd0);
    drive(0, S9, 8);
    idle(3);
    settle();
    check("idle_anodes_then_valid", 32'(n_valid - v0), 32'd1);
    check("idle_anodes_value", 32'(last_value), 32'h6669);

    // Mid-frame reset discards three captured digits.
    do_reset();
    for (int d = 2; d >= 0; d--) drive(d, S9, 8);
    do_reset();
    v0 = n_valid;
    scan({S4, S3, S2, S1}, 8);
    idle(3);
    settle();
    check("reset_midframe_valid_count", 32'(n_valid - v0), 32'd1);
    check("reset_midframe_value", 32'(last_value), 32'h4321);

    // Back-to-back frames with digit 0 changing.
    v0 = n_valid;
    scan({S1, S2, S3, S5}, 8);
    scan({S1, S2, S3, S7}, 8);
    idle(3);
    settle();
    check("continuous_valid_count", 32'(n_valid - v0), 32'd2);
    check("continuous_first_value", 32'(prev_value), 32'h1235);
    check("continuous_second_value", 32'(last_value), 32'h1237);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
